// File: rtl/train_seq_pkg.sv
// Shared state encoding and parameter defaults for the training sequencer.
package train_seq_pkg;

    localparam int AW_DEF        = 7;
    localparam int EW_DEF        = 8;
    localparam int MAX_EPOCH_DEF = 100;
    localparam int CALC_CYC_DEF  = 3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_LOAD,
        S_CALC,
        S_UPDATE,
        S_NEXT,
        S_EPOCH_END,
        S_DONE
    } state_t;

endpackage

// File: rtl/train_seq_ctrl_calc_timer.sv
// Loadable down-counter timing the datapath compute window.
// Latency: load takes effect next cycle; zero is a decode of the count register.
// Backpressure: none; counting pauses at zero or while en is low.
module calc_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/train_seq_ctrl.sv
// Sequencer for a perceptron training run: fetch, compute, update per sample, loop over epochs.
// Latency: 2 cycles start->first mem_rd; 4+CALC_CYC cycles per sample with immediate mem_valid.
// Backpressure: FETCH stalls until mem_valid; abort and rst drop straight to IDLE.
module train_seq_ctrl
    import train_seq_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int EW        = EW_DEF,
    parameter int MAX_EPOCH = MAX_EPOCH_DEF,
    parameter int CALC_CYC  = CALC_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW:0]   n_samples,
    input  logic          mem_valid,
    input  logic          err_nz,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    output logic          init_regs,
    output logic          ld_sample,
    output logic          upd_en,
    output logic          busy,
    output logic          ready,
    output logic          converged,
    output logic [EW-1:0] epoch
);

    localparam int TW = (CALC_CYC > 1) ? $clog2(CALC_CYC) : 1;

    state_t        state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic [EW-1:0] epoch_q, epoch_nxt;
    logic [AW:0]   n_lat, n_lat_nxt;
    logic          chg_flag, chg_nxt;
    logic          conv_q, conv_nxt;
    logic          tmr_zero;
    logic          last_sample;
    logic [EW-1:0] epoch_inc;

    calc_timer #(.W(TW)) u_calc_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (state == S_LOAD),
        .load_val (TW'(CALC_CYC - 1)),
        .en       (state == S_CALC),
        .zero     (tmr_zero)
    );

    assign last_sample = ({1'b0, addr} == (n_lat - 1'b1));
    assign epoch_inc   = epoch_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr     <= '0;
            epoch_q  <= '0;
            n_lat    <= '0;
            chg_flag <= 1'b0;
            conv_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            addr     <= addr_nxt;
            epoch_q  <= epoch_nxt;
            n_lat    <= n_lat_nxt;
            chg_flag <= chg_nxt;
            conv_q   <= conv_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        epoch_nxt = epoch_q;
        n_lat_nxt = n_lat;
        chg_nxt   = chg_flag;
        conv_nxt  = conv_q;
        // abort outranks every transition; epoch keeps its count for inspection
        if ((state != S_IDLE) && abort) begin
            state_nxt = S_IDLE;
            conv_nxt  = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat_nxt = n_samples;
                        epoch_nxt = '0;
                        conv_nxt  = 1'b0;
                        addr_nxt  = '0;
                        chg_nxt   = 1'b0;
                        state_nxt = S_INIT;
                    end
                end
                S_INIT: begin
                    if (n_lat == '0) begin
                        conv_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
                S_FETCH:  if (mem_valid) state_nxt = S_LOAD;
                S_LOAD:   state_nxt = S_CALC;
                S_CALC:   if (tmr_zero) state_nxt = S_UPDATE;
                S_UPDATE: begin
                    if (err_nz) chg_nxt = 1'b1;
                    state_nxt = S_NEXT;
                end
                S_NEXT: begin
                    if (last_sample) begin
                        state_nxt = S_EPOCH_END;
                    end else begin
                        addr_nxt  = addr + 1'b1;
                        state_nxt = S_FETCH;
                    end
                end
                S_EPOCH_END: begin
                    epoch_nxt = epoch_inc;
                    if (!chg_flag) begin
                        conv_nxt  = 1'b1;
                        state_nxt = S_DONE;
                    end else if (epoch_inc == EW'(MAX_EPOCH)) begin
                        conv_nxt  = 1'b0;
                        state_nxt = S_DONE;
                    end else begin
                        chg_nxt   = 1'b0;
                        addr_nxt  = '0;
                        state_nxt = S_FETCH;
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign mem_rd    = (state == S_FETCH);
    assign mem_addr  = addr;
    assign init_regs = (state == S_INIT);
    assign ld_sample = (state == S_LOAD);
    assign upd_en    = (state == S_UPDATE) & err_nz;
    assign busy      = (state != S_IDLE);
    assign ready     = (state == S_DONE);
    assign converged = conv_q;
    assign epoch     = epoch_q;

endmodule

// File: tb/tb_train_seq_ctrl.sv
// Randomised bench for train_seq_ctrl against a sample/epoch-level reference model.
module tb_train_seq_ctrl;

    localparam int AW   = 7;
    localparam int EW   = 8;
    localparam int MAXE = 5;
    localparam int CC   = 3;
    localparam int P_IDLE = 0, P_INIT = 1, P_FETCH = 2, P_SAMP = 3, P_EEND = 4, P_DONE = 5;

    typedef logic [AW:0] nsamp_t;

    logic          clk = 1'b0;
    logic          rst, start, abort, mem_valid, err_nz;
    logic [AW:0]   n_samples;
    logic          mem_rd, init_regs, ld_sample, upd_en, busy, ready, converged;
    logic [AW-1:0] mem_addr;
    logic [EW-1:0] epoch;

    always #5 clk = ~clk;

    train_seq_ctrl #(.AW(AW), .EW(EW), .MAX_EPOCH(MAXE), .CALC_CYC(CC)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_samples(n_samples),
        .mem_valid(mem_valid), .err_nz(err_nz), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .init_regs(init_regs), .ld_sample(ld_sample), .upd_en(upd_en), .busy(busy),
        .ready(ready), .converged(converged), .epoch(epoch)
    );

    int n_tests = 0, n_fail = 0, cyc = 0;
    int dly_mode = 0, err_mode = 0;
    bit mv_noise = 1'b0, noisy = 1'b0;
    int ready_cnt = 0, upd_cnt = 0, rd_cnt = 0, ld_cnt = 0, init_cnt = 0;
    int rd_run = 0, rd_min = 1000, rd_max = 0;

    // reference model: phase of the run plus offset j inside one sample's
    // post-fetch window (0 load, 1..CC compute, CC+1 update, CC+2 advance)
    int ph = P_IDLE, j = 0, m_addr = 0, m_epoch = 0, m_n = 0;
    bit m_chg = 1'b0, m_conv = 1'b0, m_ok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (m_ok) begin
                chk("busy",      32'(busy),      32'(ph != P_IDLE));
                chk("ready",     32'(ready),     32'(ph == P_DONE));
                chk("init_regs", 32'(init_regs), 32'(ph == P_INIT));
                chk("mem_rd",    32'(mem_rd),    32'(ph == P_FETCH));
                chk("ld_sample", 32'(ld_sample), 32'(ph == P_SAMP && j == 0));
                chk("upd_en",    32'(upd_en),    32'(ph == P_SAMP && j == CC + 1 && err_nz));
                chk("converged", 32'(converged), 32'(m_conv));
                chk("epoch",     32'(epoch),     32'(m_epoch));
                if (ph == P_FETCH) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
                if (ready === 1'b1) ready_cnt++;
                if (upd_en === 1'b1) upd_cnt++;
                if (ld_sample === 1'b1) ld_cnt++;
                if (init_regs === 1'b1) init_cnt++;
                if (mem_rd === 1'b1) begin
                    rd_cnt++;
                    rd_run++;
                end else if (rd_run > 0) begin
                    if (rd_run < rd_min) rd_min = rd_run;
                    if (rd_run > rd_max) rd_max = rd_run;
                    rd_run = 0;
                end
            end
            @(posedge clk);
            if (rst) begin
                ph = P_IDLE; m_addr = 0; m_epoch = 0; m_chg = 0; m_conv = 0; m_ok = 1'b1;
            end else if (m_ok) begin
                if (ph != P_IDLE && abort) begin
                    ph = P_IDLE;
                    m_conv = 0;
                end else begin
                    case (ph)
                        P_IDLE: if (start) begin
                            m_n = int'(n_samples); m_epoch = 0; m_conv = 0;
                            m_addr = 0; m_chg = 0; ph = P_INIT;
                        end
                        P_INIT: begin
                            if (m_n == 0) begin m_conv = 1; ph = P_DONE; end
                            else ph = P_FETCH;
                        end
                        P_FETCH: if (mem_valid) begin ph = P_SAMP; j = 0; end
                        P_SAMP: begin
                            if (j == CC + 1 && err_nz) m_chg = 1;
                            if (j == CC + 2) begin
                                if (m_addr == m_n - 1) ph = P_EEND;
                                else begin m_addr++; ph = P_FETCH; end
                            end else j++;
                        end
                        P_EEND: begin
                            m_epoch++;
                            if (!m_chg) begin m_conv = 1; ph = P_DONE; end
                            else if (m_epoch == MAXE) begin m_conv = 0; ph = P_DONE; end
                            else begin m_chg = 0; m_addr = 0; ph = P_FETCH; end
                        end
                        default: ph = P_IDLE;
                    endcase
                end
            end
        end
    end

    // memory / datapath responder
    initial begin
        int wc, cd;
        wc = 0; cd = 0;
        mem_valid = 1'b0;
        err_nz = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (err_mode)
                0:       err_nz = 1'b0;
                1:       err_nz = 1'b1;
                2:       err_nz = (epoch == '0);
                default: err_nz = 1'($urandom_range(0, 1));
            endcase
            if (mem_rd === 1'b1) begin
                mem_valid = (wc >= cd);
                wc++;
            end else begin
                wc = 0;
                cd = (dly_mode < 0) ? int'($urandom_range(0, 3)) : dly_mode;
                mem_valid = mv_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (noisy) begin
            abort     = ($urandom_range(0, 149) == 0);
            start     = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            n_samples = nsamp_t'($urandom_range(0, 6));
        end
    endtask

    task automatic run(input int n, output int lat);
        bit fin;
        fin = 1'b0;
        n_samples = nsamp_t'(n);
        start = 1'b1;
        step();
        if (!noisy) start = 1'b0;
        lat = -1;
        for (int t = 1; t <= 3000 && !fin; t++) begin
            @(negedge clk);
            if (ready === 1'b1 && lat < 0) lat = t;
            if (busy === 1'b0) fin = 1'b1;
            else if (t == 3000) chk("run_timeout", 32'(busy), 32'd0);
            else step();
        end
        step();
    endtask

    initial begin
        int lat, r0, u0, rd0, l0, i0;
        bit hit;
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_samples = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_epoch", 32'(epoch), 32'd0);
        chk("rst_conv",  32'(converged), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        step();

        // S1: 4 samples, clean data -> converged after one epoch
        err_mode = 0; dly_mode = 0; r0 = ready_cnt;
        run(4, lat);
        chk("s1_latency", 32'(lat), 32'd31);
        chk("s1_conv", 32'(converged), 32'd1);
        chk("s1_epoch", 32'(epoch), 32'd1);
        chk("s1_ready_cnt", 32'(ready_cnt - r0), 32'd1);

        // S2: errors only in the first epoch
        err_mode = 2; u0 = upd_cnt;
        run(2, lat);
        chk("s2_epoch", 32'(epoch), 32'd2);
        chk("s2_conv", 32'(converged), 32'd1);
        chk("s2_upd_cnt", 32'(upd_cnt - u0), 32'd2);

        // S3: errors forever -> epoch limit
        err_mode = 1; r0 = ready_cnt;
        run(3, lat);
        chk("s3_epoch", 32'(epoch), 32'd5);
        chk("s3_conv", 32'(converged), 32'd0);
        chk("s3_ready_cnt", 32'(ready_cnt - r0), 32'd1);

        // S4: empty sample set
        err_mode = 0; rd0 = rd_cnt; i0 = init_cnt;
        run(0, lat);
        chk("s4_latency", 32'(lat), 32'd2);
        chk("s4_init_cnt", 32'(init_cnt - i0), 32'd1);
        chk("s4_rd_cnt", 32'(rd_cnt - rd0), 32'd0);
        chk("s4_conv", 32'(converged), 32'd1);
        chk("s4_epoch", 32'(epoch), 32'd0);

        // S5: memory answers on the fourth request cycle
        dly_mode = 3; rd_min = 1000; rd_max = 0; l0 = ld_cnt;
        run(2, lat);
        chk("s5_rd_min", 32'(rd_min), 32'd4);
        chk("s5_rd_max", 32'(rd_max), 32'd4);
        chk("s5_ld_cnt", 32'(ld_cnt - l0), 32'd2);
        chk("s5_conv", 32'(converged), 32'd1);
        dly_mode = 0;

        // S6: abort during compute, then reset during fetch, then a clean run
        r0 = ready_cnt; hit = 1'b0;
        n_samples = nsamp_t'(3); start = 1'b1; step(); start = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge clk);
            if (ph == P_SAMP && j == 1) hit = 1'b1;
            else step();
        end
        chk("s6_reach_calc", 32'(hit), 32'd1);
        abort = 1'b1; step(); abort = 1'b0;
        @(negedge clk);
        chk("s6_abort_busy", 32'(busy), 32'd0);
        chk("s6_abort_conv", 32'(converged), 32'd0);
        chk("s6_abort_ready", 32'(ready_cnt - r0), 32'd0);
        step();
        hit = 1'b0;
        n_samples = nsamp_t'(3); start = 1'b1; step(); start = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            @(negedge clk);
            if (mem_rd === 1'b1) hit = 1'b1;
            else step();
        end
        chk("s6_reach_fetch", 32'(hit), 32'd1);
        rst = 1'b1; step(); rst = 1'b0;
        @(negedge clk);
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_epoch", 32'(epoch), 32'd0);
        chk("s6_rst_ready", 32'(ready_cnt - r0), 32'd0);
        step();
        run(2, lat);
        chk("s6_rerun_conv", 32'(converged), 32'd1);
        chk("s6_rerun_epoch", 32'(epoch), 32'd1);
        chk("s6_rerun_ready", 32'(ready_cnt - r0), 32'd1);

        // randomised runs with noise on every control input
        noisy = 1'b1; mv_noise = 1'b1; dly_mode = -1; err_mode = 3;
        for (int k = 0; k < 30; k++) run(int'($urandom_range(0, 6)), lat);
        noisy = 1'b0; start = 1'b0; abort = 1'b0; rst = 1'b0;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/train_seq_ctrl.md
TRAIN_SEQ_CTRL -- requirements
Module: train_seq_ctrl

Interface
REQ-001 SHALL have parameter AW, default 7: sample address width.
REQ-002 SHALL have parameter EW, default 8: epoch counter width.
REQ-003 SHALL have parameter MAX_EPOCH, default 100: epoch limit, 1..2^EW-1.
REQ-004 SHALL have parameter CALC_CYC, default 3: datapath compute wait, in cycles, >=1.
REQ-005 SHALL have the following ports:
  clk  in  1  single clock; all state updates on its rising edge.
  rst  in  1  synchronous, active-high reset.
  start  in  1  begin training run.
  abort  in  1  cancel run.
  n_samples  in  AW+1  number of samples per epoch.
  mem_valid  in  1  sample memory data valid.
  err_nz  in  1  datapath: current sample error nonzero; weights must update.
  mem_rd  out  1  sample memory read request.
  mem_addr  out  AW  sample address.
  init_regs  out  1  clear datapath x1/x2/t/w1/w2/b registers.
  ld_sample  out  1  load x1/x2/t from memory data.
  upd_en  out  1  load w1/w2/b.
  busy  out  1  run in progress.
  ready  out  1  one-cycle run-complete pulse.
  converged  out  1  last run ended with an error-free epoch.
  epoch  out  EW  completed epochs of current or last run.

Function
REQ-006 SHALL implement states IDLE, INIT, FETCH, LOAD, CALC, UPDATE, NEXT, EPOCH_END, DONE.
REQ-007 IDLE: start=1 SHALL latch n_samples, clear epoch, converged, addr and chg_flag, then go to INIT; start is ignored in every other state.
REQ-008 INIT: init_regs=1 for exactly one cycle; go to FETCH, or to DONE with converged=1 when latched n_samples=0.
REQ-009 FETCH: mem_rd=1 and mem_addr=addr on every FETCH cycle; stay until mem_valid=1, then go to LOAD; mem_valid outside FETCH is ignored.
REQ-010 LOAD: ld_sample=1 for one cycle; go to CALC; load the calc timer with CALC_CYC-1.
REQ-011 CALC: stay exactly CALC_CYC cycles; go to UPDATE.
REQ-012 UPDATE: upd_en=err_nz, sampled in this cycle; err_nz=1 sets chg_flag; go to NEXT.
REQ-013 NEXT: if addr==n_samples-1, go to EPOCH_END; else addr+1 and go to FETCH.
REQ-014 EPOCH_END: epoch+1.
  - chg_flag=0 -> converged=1, go to DONE.
  - else epoch+1==MAX_EPOCH -> converged=0, go to DONE.
  - else clear chg_flag, addr=0, go to FETCH.
REQ-015 DONE: ready=1 for one cycle; go to IDLE; converged and epoch hold until the next start.
REQ-016 busy SHALL be 1 in all states except IDLE.
REQ-017 abort=1 in any non-IDLE state SHALL force IDLE next cycle, with no ready pulse, converged=0, and epoch holding its value; abort has priority over every other transition.
REQ-018 Per-sample cost SHALL be 4+CALC_CYC cycles when mem_valid is returned in the first FETCH cycle.
REQ-019 start-to-first-mem_rd latency SHALL be 2 cycles (IDLE->INIT->FETCH).
REQ-020 All outputs SHALL be registered-state decodes, with no combinational path from inputs to outputs except upd_en from err_nz.
REQ-021 The epoch counter SHALL never wrap; MAX_EPOCH bounds it.

Reset
REQ-022 rst=1 SHALL, at the next edge, set: state=IDLE; addr=0; epoch=0; chg_flag=0; converged=0; all strobes, busy and ready 0.
REQ-023 rst SHALL take priority over abort and start, including mid-run.
REQ-024 rst SHALL generate no ready pulse.

Structure
REQ-025 Package train_seq_pkg SHALL hold the state enumeration and the default values of AW, EW, MAX_EPOCH and CALC_CYC.
REQ-026 Sub-module calc_timer SHALL be a loadable down-counter that raises its zero flag on the CALC cycle that exits.
REQ-027 The controller SHALL remain a single FSM plus addr, epoch and chg_flag registers.

Verification
REQ-028 Scenario 1: n_samples=4, CALC_CYC=3, mem_valid immediate, err_nz=0 always. Required: ready exactly 2+4*7+1 cycles after start; converged=1; epoch=1.
REQ-029 Scenario 2: n_samples=2, err_nz=1 in epoch 1 only. Required: epoch=2; converged=1; upd_en pulses exactly twice.
REQ-030 Scenario 3: err_nz=1 always, MAX_EPOCH=5. Required: epoch=5; converged=0; one ready pulse.
REQ-031 Scenario 4: n_samples=0. Required: init_regs, then ready; no mem_rd ever; converged=1; epoch=0.
REQ-032 Scenario 5: mem_valid delayed 3 cycles per sample. Required: mem_rd held 4 cycles; mem_addr stable; ld_sample one cycle after mem_valid.
REQ-033 Scenario 6: abort in CALC, then rst in FETCH of a new run. Required: IDLE next cycle each time; no ready; a subsequent start runs normally from addr 0.
